// File: rtl/shreg256_seq_pkg.sv
// Shared constants for the shreg256 sequencer: geometry, FSM state
// encodings and the shift-amount clamp helper.
package shreg256_seq_pkg;

   localparam int WW       = 16;
   localparam int NWORDS   = 16;
   localparam int SAW      = 9;
   localparam int CNTW     = 4;

   localparam logic [SAW-1:0] MAXSHIFT = 9'd256;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_LOADED = 3'd2;
   localparam logic [2:0] ST_SHIFT  = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   // A register of 256 bits is all zero after 256 shifts, so larger
   // requests collapse to the full-width shift.
   function automatic logic [SAW-1:0] clamp_amt(input logic [SAW-1:0] amt);
      logic [SAW-1:0] res;
      if (amt > MAXSHIFT) begin
         res = MAXSHIFT;
      end else begin
         res = amt;
      end
      return res;
   endfunction

endpackage

// File: rtl/shreg256_seq_bitcap.sv
// Collects the bits shifted out of the register MSB into 16-bit words.
// A word is emitted (registered, one cycle later) after every 16th bit;
// a partial word is flushed right-aligned when the shift command ends.
module shreg256_bitcap
   import shreg256_seq_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_shift,
   input  logic          i_done,
   input  logic          i_b256,
   output logic [WW-1:0] o_cap_word,
   output logic          o_cap_valid
);

   logic          r_shift_d;
   logic [CNTW:0] r_cnt;
   logic [WW-1:0] r_cap;
   logic [WW-1:0] r_cap_word;
   logic          r_cap_valid;
   logic [CNTW:0] w_cnt_nxt;
   logic [WW-1:0] w_cap_nxt;

   // Fold in the bit that becomes valid the cycle after a shift cycle.
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_cap_nxt = r_cap;
      if (r_shift_d) begin
         w_cnt_nxt = r_cnt + 5'd1;
         w_cap_nxt = {r_cap[WW-2:0], i_b256};
      end else begin
         w_cnt_nxt = r_cnt;
         w_cap_nxt = r_cap;
      end
   end

   // Capture state, full-word emission and end-of-command flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_shift_d   <= 1'b0;
         r_cnt       <= 5'd0;
         r_cap       <= 16'h0000;
         r_cap_word  <= 16'h0000;
         r_cap_valid <= 1'b0;
      end else begin
         r_shift_d   <= i_shift;
         r_cap_valid <= 1'b0;
         if (w_cnt_nxt == 5'd16) begin
            r_cap_word  <= w_cap_nxt;
            r_cap_valid <= 1'b1;
            r_cnt       <= 5'd0;
            r_cap       <= 16'h0000;
         end else if (i_done) begin
            if (w_cnt_nxt != 5'd0) begin
               r_cap_word  <= w_cap_nxt;
               r_cap_valid <= 1'b1;
            end else begin
               r_cap_valid <= 1'b0;
            end
            r_cnt <= 5'd0;
            r_cap <= 16'h0000;
         end else begin
            r_cnt <= w_cnt_nxt;
            r_cap <= w_cap_nxt;
         end
      end
   end

   assign o_cap_word  = r_cap_word;
   assign o_cap_valid = r_cap_valid;

endmodule

// File: rtl/shreg256_seq.sv
// Sequencer in front of the 256-bit load/left-shift register: loads an
// operand as 16 words (LSW first), then runs commanded 1-bit-per-cycle
// left shifts and pulses done at the end of each command.
// Optional macro SHREG256_BITCAP_EN adds the cap_word/cap_valid capture
// of bits shifted out of the register MSB.
module shreg256_seq
   import shreg256_seq_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           load_start,
   input  logic [WW-1:0]  in_data,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [SAW-1:0] shift_amt,
   input  logic           shift_valid,
   output logic           shift_ready,
   output logic           done,
   output logic           loaded,
   output logic [WW-1:0]  sr_regin,
   output logic           sr_we,
   output logic           sr_sel_ls,
   input  logic           sr_b256
`ifdef SHREG256_BITCAP_EN
   ,
   output logic [WW-1:0]  cap_word,
   output logic           cap_valid
`endif
);

   logic [2:0]      r_state;
   logic [CNTW-1:0] r_wcnt;
   logic [SAW-1:0]  r_rem;
   logic            w_word_acc;
   logic [SAW-1:0]  w_amt;

   // A restart request in LOAD takes the cycle, so no word is taken then.
   assign w_word_acc = (r_state == ST_LOAD) && !load_start && in_valid;
   assign w_amt      = clamp_amt(shift_amt);

   // Handshake and register-control outputs decoded from the state.
   always_comb begin
      in_ready    = 1'b0;
      shift_ready = 1'b0;
      done        = 1'b0;
      loaded      = 1'b0;
      sr_regin    = 16'h0000;
      sr_we       = 1'b0;
      sr_sel_ls   = 1'b0;
      case (r_state)
         ST_LOAD: begin
            in_ready = !load_start;
            if (w_word_acc) begin
               sr_we    = 1'b1;
               sr_regin = in_data;
            end else begin
               sr_we    = 1'b0;
               sr_regin = 16'h0000;
            end
         end
         ST_LOADED: begin
            loaded      = 1'b1;
            shift_ready = !load_start;
         end
         ST_SHIFT: begin
            sr_we     = 1'b1;
            sr_sel_ls = 1'b1;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
            in_ready = 1'b0;
         end
      endcase
   end

   // FSM with word counter and remaining-shift counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_wcnt  <= 4'd0;
         r_rem   <= 9'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (load_start) begin
                  r_state <= ST_LOAD;
                  r_wcnt  <= 4'd0;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               if (load_start) begin
                  r_wcnt <= 4'd0;
               end else if (in_valid) begin
                  r_wcnt <= r_wcnt + 4'd1;
                  if (r_wcnt == 4'(NWORDS - 1)) begin
                     r_state <= ST_LOADED;
                  end else begin
                     r_state <= ST_LOAD;
                  end
               end else begin
                  r_wcnt <= r_wcnt;
               end
            end
            ST_LOADED: begin
               if (load_start) begin
                  r_state <= ST_LOAD;
                  r_wcnt  <= 4'd0;
               end else if (shift_valid) begin
                  if (w_amt == 9'd0) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_state <= ST_SHIFT;
                     r_rem   <= w_amt;
                  end
               end else begin
                  r_state <= ST_LOADED;
               end
            end
            ST_SHIFT: begin
               r_rem <= r_rem - 9'd1;
               if (r_rem == 9'd1) begin
                  r_state <= ST_DONE;
               end else begin
                  r_state <= ST_SHIFT;
               end
            end
            ST_DONE: begin
               r_state <= ST_LOADED;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef SHREG256_BITCAP_EN
   shreg256_bitcap u_bitcap (
      .clk         (clk),
      .rst         (rst),
      .i_shift     (sr_we & sr_sel_ls),
      .i_done      (done),
      .i_b256      (sr_b256),
      .o_cap_word  (cap_word),
      .o_cap_valid (cap_valid)
   );
`else
   logic w_unused_b256;
   assign w_unused_b256 = sr_b256;
`endif

endmodule

// File: tb/tb_shreg256_seq.sv
// Directed bench for shreg256_seq with a behavioural model of the
// downstream 256-bit register (word load shifts in at the top so the
// first word ends up lowest; left shift exposes the MSB one cycle later).
module tb_shreg256_seq;

   logic         clk = 1'b0;
   logic         rst;
   logic         load_start;
   logic [15:0]  in_data;
   logic         in_valid;
   logic         in_ready;
   logic [8:0]   shift_amt;
   logic         shift_valid;
   logic         shift_ready;
   logic         done;
   logic         loaded;
   logic [15:0]  sr_regin;
   logic         sr_we;
   logic         sr_sel_ls;
   logic         sr_b256;
`ifdef SHREG256_BITCAP_EN
   logic [15:0]  cap_word;
   logic         cap_valid;
   int           cap_cnt;
   logic [15:0]  cap_first;
   int           cap_bad;
`endif

   int           vecs = 0;
   int           errs = 0;
   logic [15:0]  words [16];
   logic [255:0] op;
   logic [255:0] m_reg = '0;
   logic         m_b256 = 1'b0;
   int           m_shifts = 0;

   always #5 clk = ~clk;

   shreg256_seq dut (
      .clk         (clk),
      .rst         (rst),
      .load_start  (load_start),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .shift_amt   (shift_amt),
      .shift_valid (shift_valid),
      .shift_ready (shift_ready),
      .done        (done),
      .loaded      (loaded),
      .sr_regin    (sr_regin),
      .sr_we       (sr_we),
      .sr_sel_ls   (sr_sel_ls),
      .sr_b256     (sr_b256)
`ifdef SHREG256_BITCAP_EN
      ,
      .cap_word    (cap_word),
      .cap_valid   (cap_valid)
`endif
   );

   assign sr_b256 = m_b256;

   // downstream register model
   always @(posedge clk) begin
      if (sr_we) begin
         if (sr_sel_ls) begin
            m_b256   <= m_reg[255];
            m_reg    <= {m_reg[254:0], 1'b0};
            m_shifts <= m_shifts + 1;
         end else begin
            m_reg <= {sr_regin, m_reg[255:16]};
         end
      end
   end

`ifdef SHREG256_BITCAP_EN
   // capture monitor
   always @(posedge clk) begin
      if (cap_valid) begin
         if (cap_cnt == 0) cap_first <= cap_word;
         else if (cap_word !== 16'h0000) cap_bad <= cap_bad + 1;
         cap_cnt <= cap_cnt + 1;
      end
   end
`endif

   task automatic set_words(input logic [15:0] base, input logic [15:0] step);
      for (int i = 0; i < 16; i++) begin
         words[i] = base + step * 16'(i);
         op[i*16 +: 16] = words[i];
      end
   endtask

   task automatic load_words(input bit toggle);
      int acc;
      int c;
      @(negedge clk);
      load_start = 1'b1; in_valid = 1'b0; shift_valid = 1'b0;
      #1; vecs++;
      if (in_ready !== 1'b0 || sr_we !== 1'b0) begin
         errs++; $display("FAIL load_start_cycle: in_ready=%b sr_we=%b want 0/0", in_ready, sr_we);
      end
      acc = 0; c = 0;
      while (acc < 16 && c < 40) begin
         @(negedge clk);
         load_start = 1'b0;
         in_valid = toggle ? ((c % 2) == 0) : 1'b1;
         in_data  = in_valid ? words[acc] : 16'hBEEF;
         #1; vecs++;
         if (in_ready !== 1'b1 || sr_we !== in_valid || sr_sel_ls !== 1'b0 || loaded !== 1'b0) begin
            errs++; $display("FAIL load_word%0d: rdy/we/sel/loaded=%b%b%b%b want 1%b00", acc, in_ready, sr_we, sr_sel_ls, loaded, in_valid);
         end
         if (in_valid) begin
            vecs++;
            if (sr_regin !== words[acc]) begin
               errs++; $display("FAIL load_regin%0d: got %h want %h", acc, sr_regin, words[acc]);
            end
            acc++;
         end
         c++;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1; vecs++;
      if (loaded !== 1'b1 || in_ready !== 1'b0 || sr_we !== 1'b0) begin
         errs++; $display("FAIL loaded_after_16: loaded/rdy/we=%b%b%b want 100", loaded, in_ready, sr_we);
      end
      vecs++;
      if (m_reg !== op) begin
         errs++; $display("FAIL load_contents: got %h want %h", m_reg, op);
      end
   endtask

   task automatic do_shift(input logic [8:0] amt, input int eff);
      int s0;
      @(negedge clk);
      shift_amt = amt; shift_valid = 1'b1;
      #1; vecs++;
      if (shift_ready !== 1'b1 || loaded !== 1'b1) begin
         errs++; $display("FAIL shift_accept: ready=%b loaded=%b want 1/1", shift_ready, loaded);
      end
      s0 = m_shifts;
      @(negedge clk);
      shift_valid = 1'b0;
      for (int k = 1; k <= eff + 1; k++) begin
         load_start = (eff >= 3 && k == 2);
         #1; vecs++;
         if (k <= eff) begin
            if (sr_we !== 1'b1 || sr_sel_ls !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0 || shift_ready !== 1'b0) begin
               errs++; $display("FAIL shift_cyc%0d: we/sel/done/rdy/srdy=%b%b%b%b%b want 11000", k, sr_we, sr_sel_ls, done, in_ready, shift_ready);
            end
         end else begin
            if (done !== 1'b1 || sr_we !== 1'b0 || sr_sel_ls !== 1'b0 || loaded !== 1'b0) begin
               errs++; $display("FAIL shift_done: done/we/sel/loaded=%b%b%b%b want 1000", done, sr_we, sr_sel_ls, loaded);
            end
         end
         @(negedge clk);
      end
      load_start = 1'b0;
      #1; vecs++;
      if (loaded !== 1'b1 || done !== 1'b0 || sr_we !== 1'b0) begin
         errs++; $display("FAIL after_done: loaded/done/we=%b%b%b want 100", loaded, done, sr_we);
      end
      vecs++;
      if (m_shifts - s0 != eff) begin
         errs++; $display("FAIL shift_count: got %0d want %0d", m_shifts - s0, eff);
      end
      op = (eff >= 256) ? 256'd0 : (op << eff);
      vecs++;
      if (m_reg !== op) begin
         errs++; $display("FAIL shift_contents: got %h want %h", m_reg, op);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = 16'h0;
      shift_valid = 1'b1; shift_amt = 9'd3;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1; vecs++;
      if ({in_ready, shift_ready, done, loaded, sr_we, sr_sel_ls} !== 6'b0 || sr_regin !== 16'h0) begin
         errs++; $display("FAIL reset_outputs: flags=%b regin=%h want 0", {in_ready, shift_ready, done, loaded, sr_we, sr_sel_ls}, sr_regin);
      end
      shift_valid = 1'b0;
   endtask

   task automatic test_load_burst;
      set_words(16'h0001, 16'h0001);
      load_words(1'b0);
      vecs++;
      if (m_reg[15:0] !== 16'h0001) begin
         errs++; $display("FAIL low_word: got %h want 0001", m_reg[15:0]);
      end
   endtask

   task automatic test_load_toggle;
      set_words(16'hA5C3, 16'h1111);
      load_words(1'b1);
   endtask

   task automatic test_shift_small;
      do_shift(9'd5, 5);
      do_shift(9'd0, 0);
   endtask

   task automatic test_shift_full;
`ifdef SHREG256_BITCAP_EN
      cap_cnt = 0; cap_bad = 0; cap_first = 16'h0;
`endif
      for (int i = 0; i < 16; i++) words[i] = 16'h0000;
      words[15] = 16'h8000;
      op = 256'd0; op[255] = 1'b1;
      load_words(1'b0);
      do_shift(9'd256, 256);
      @(negedge clk); @(negedge clk);
`ifdef SHREG256_BITCAP_EN
      vecs++;
      if (cap_cnt != 16 || cap_first !== 16'h8000 || cap_bad != 0) begin
         errs++; $display("FAIL bitcap: cnt=%0d first=%h bad=%0d want 16/8000/0", cap_cnt, cap_first, cap_bad);
      end
`endif
      set_words(16'hFFFF, 16'h0000);
      load_words(1'b0);
      do_shift(9'd300, 256);
   endtask

   task automatic test_load_priority;
      @(negedge clk);
      load_start = 1'b1; shift_valid = 1'b1; shift_amt = 9'd4;
      #1; vecs++;
      if (shift_ready !== 1'b0 || loaded !== 1'b1) begin
         errs++; $display("FAIL prio_same_cycle: shift_ready=%b loaded=%b want 0/1", shift_ready, loaded);
      end
      @(negedge clk);
      load_start = 1'b0; shift_valid = 1'b0; in_valid = 1'b0;
      #1; vecs++;
      if (in_ready !== 1'b1 || loaded !== 1'b0 || sr_we !== 1'b0) begin
         errs++; $display("FAIL prio_in_load: rdy/loaded/we=%b%b%b want 100", in_ready, loaded, sr_we);
      end
      set_words(16'h1000, 16'h0101);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); in_valid = 1'b1; in_data = 16'h7777;
      end
      @(negedge clk);
      load_start = 1'b1; in_valid = 1'b1; in_data = 16'h6666;
      #1; vecs++;
      if (sr_we !== 1'b0 || in_ready !== 1'b0) begin
         errs++; $display("FAIL restart_no_accept: we=%b rdy=%b want 0/0", sr_we, in_ready);
      end
      in_valid = 1'b0;
      load_words(1'b0);
   endtask

   task automatic test_reset_midshift;
      int s0;
      @(negedge clk);
      shift_amt = 9'd10; shift_valid = 1'b1;
      s0 = m_shifts;
      @(negedge clk); shift_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1; vecs++;
      if (sr_we !== 1'b1 || sr_sel_ls !== 1'b1) begin
         errs++; $display("FAIL third_shift: we=%b sel=%b want 1/1", sr_we, sr_sel_ls);
      end
      @(negedge clk);
      rst = 1'b0;
      #1; vecs++;
      if ({in_ready, shift_ready, done, loaded, sr_we, sr_sel_ls} !== 6'b0 || sr_regin !== 16'h0) begin
         errs++; $display("FAIL post_rst: flags=%b regin=%h want 0", {in_ready, shift_ready, done, loaded, sr_we, sr_sel_ls}, sr_regin);
      end
      vecs++;
      if (m_shifts - s0 != 3) begin
         errs++; $display("FAIL rst_shift_count: got %0d want 3", m_shifts - s0);
      end
      @(negedge clk);
      shift_valid = 1'b1;
      #1; vecs++;
      if (shift_ready !== 1'b0 || sr_we !== 1'b0) begin
         errs++; $display("FAIL idle_ignores_shift: ready=%b we=%b want 0/0", shift_ready, sr_we);
      end
      shift_valid = 1'b0;
      set_words(16'h0F0F, 16'h0123);
      load_words(1'b0);
      do_shift(9'd1, 1);
   endtask

   initial begin
      test_reset;
      test_load_burst;
      test_load_toggle;
      test_shift_small;
      test_shift_full;
      test_load_priority;
      test_reset_midshift;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
